// File: rtl/arm_pipe_pkg.sv
// ---------------------------------------------------------------------------
// arm_pipe_pkg
// Types shared by the pipelined ARM core stages.
//   WIDTH       datapath width
//   alu_op_e    ALU operation encoding (ALUControl)
//   cond_e      the sixteen ARM condition codes
//   fwd_sel_e   operand forwarding select encoding
//   ex_ctrl_t   control bundle arriving from the ID/EX register
//   mem_ctrl_t  control bundle carried into the memory stage
//   fwdMux      forwarding mux helper
//   condCheck   condition-field evaluation against an NZCV value
// ---------------------------------------------------------------------------
package arm_pipe_pkg;

   localparam int WIDTH = 32;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_ORR = 2'b11
   } alu_op_e;

   typedef enum logic [3:0] {
      COND_EQ = 4'b0000,
      COND_NE = 4'b0001,
      COND_CS = 4'b0010,
      COND_CC = 4'b0011,
      COND_MI = 4'b0100,
      COND_PL = 4'b0101,
      COND_VS = 4'b0110,
      COND_VC = 4'b0111,
      COND_HI = 4'b1000,
      COND_LS = 4'b1001,
      COND_GE = 4'b1010,
      COND_LT = 4'b1011,
      COND_GT = 4'b1100,
      COND_LE = 4'b1101,
      COND_AL = 4'b1110,
      COND_NV = 4'b1111
   } cond_e;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10,
      FWD_RF2 = 2'b11
   } fwd_sel_e;

   typedef struct packed {
      logic       PCSrc;
      logic       RegWrite;
      logic       MemtoReg;
      logic       MemWrite;
      logic       Branch;
      logic       ALUSrc;
      alu_op_e    ALUControl;
      logic [1:0] FlagWrite;
      cond_e      Cond;
   } ex_ctrl_t;

   typedef struct packed {
      logic PCSrc;
      logic RegWrite;
      logic MemtoReg;
      logic MemWrite;
   } mem_ctrl_t;

   // The unused 11 encoding falls back to the register file value.
   function automatic logic [WIDTH-1:0] fwdMux(input fwd_sel_e sel,
                                               input logic [WIDTH-1:0] rfVal,
                                               input logic [WIDTH-1:0] wbVal,
                                               input logic [WIDTH-1:0] memVal);
      logic [WIDTH-1:0] val;
      val = rfVal;
      case (sel)
         FWD_WB:  val = wbVal;
         FWD_MEM: val = memVal;
         default: val = rfVal;
      endcase
      return val;
   endfunction

   // NZCV is packed with N at bit 3. NV (1111) never executes.
   function automatic logic condCheck(input cond_e cond, input logic [3:0] nzcv);
      logic n, z, c, v, pass;
      {n, z, c, v} = nzcv;
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = ~z;
         COND_CS: pass = c;
         COND_CC: pass = ~c;
         COND_MI: pass = n;
         COND_PL: pass = ~n;
         COND_VS: pass = v;
         COND_VC: pass = ~v;
         COND_HI: pass = c & ~z;
         COND_LS: pass = ~c | z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = ~z & (n == v);
         COND_LE: pass = z | (n != v);
         COND_AL: pass = 1'b1;
         default: pass = 1'b0;
      endcase
      return pass;
   endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// ---------------------------------------------------------------------------
// ex_mem_stage_if
// Signals between the ID/EX register, the execute stage, and the memory stage.
//   ID/EX side : CtrlE, RD1E, RD2E, ExtImmE, WA3E
//   hazard unit: ForwardAE, ForwardBE, StallM, FlushM
//   writeback  : ResultW
//   outputs    : FlagsE, BranchTakenE, CtrlM, ALUResultM, WriteDataM, WA3M
// master drives the stage inputs; slave is the execute stage itself.
// ---------------------------------------------------------------------------
interface ex_mem_stage_if;
   import arm_pipe_pkg::*;

   ex_ctrl_t         CtrlE;
   logic [WIDTH-1:0] RD1E;
   logic [WIDTH-1:0] RD2E;
   logic [WIDTH-1:0] ExtImmE;
   logic [3:0]       WA3E;
   fwd_sel_e         ForwardAE;
   fwd_sel_e         ForwardBE;
   logic [WIDTH-1:0] ResultW;
   logic             StallM;
   logic             FlushM;

   logic [3:0]       FlagsE;
   logic             BranchTakenE;
   mem_ctrl_t        CtrlM;
   logic [WIDTH-1:0] ALUResultM;
   logic [WIDTH-1:0] WriteDataM;
   logic [3:0]       WA3M;

   modport master (
      output CtrlE, RD1E, RD2E, ExtImmE, WA3E, ForwardAE, ForwardBE,
             ResultW, StallM, FlushM,
      input  FlagsE, BranchTakenE, CtrlM, ALUResultM, WriteDataM, WA3M
   );

   modport slave (
      input  CtrlE, RD1E, RD2E, ExtImmE, WA3E, ForwardAE, ForwardBE,
             ResultW, StallM, FlushM,
      output FlagsE, BranchTakenE, CtrlM, ALUResultM, WriteDataM, WA3M
   );

endinterface

// File: rtl/ex_mem_stage_alu.sv
// ---------------------------------------------------------------------------
// ex_alu
// Combinational ALU with NZCV generation.
//   srcA, srcB  operands
//   aluOp       ADD / SUB / AND / ORR
//   result      WIDTH-bit result (carry out dropped)
//   nzcv        flags for this result, N at bit 3
// ---------------------------------------------------------------------------
module ex_alu
   import arm_pipe_pkg::*;
(
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  alu_op_e          aluOp,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       nzcv
);

   logic             isSub;
   logic [WIDTH-1:0] bOperand;
   logic [WIDTH:0]   sum;
   logic             carry;
   logic             overflow;

   // Subtraction reuses the adder as A + ~B + 1, so C=1 means no borrow.
   // Overflow: operands of equal sign produce a result of the other sign.
   always_comb begin
      isSub    = (aluOp == ALU_SUB);
      bOperand = isSub ? ~srcB : srcB;
      sum      = {1'b0, srcA} + {1'b0, bOperand} + {{WIDTH{1'b0}}, isSub};
      result   = sum[WIDTH-1:0];
      carry    = 1'b0;
      overflow = 1'b0;
      case (aluOp)
         ALU_ADD, ALU_SUB: begin
            result   = sum[WIDTH-1:0];
            carry    = sum[WIDTH];
            overflow = (srcA[WIDTH-1] == bOperand[WIDTH-1]) &&
                       (sum[WIDTH-1] != srcA[WIDTH-1]);
         end
         ALU_AND: result = srcA & srcB;
         ALU_ORR: result = srcA | srcB;
         default: result = sum[WIDTH-1:0];
      endcase
      nzcv = {result[WIDTH-1], (result == '0), carry, overflow};
   end

endmodule

// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
// Execute stage plus EX/MEM pipeline register. Forwards operands, runs the
// ALU, evaluates the condition field against the NZCV register owned here,
// and registers condition-gated control and data for the memory stage.
//   clk    rising-edge clock
//   reset  asynchronous, active-low; clears the flags and EX/MEM register
//   bus    ex_mem_stage_if slave (ID/EX inputs, hazard controls, M outputs)
// ---------------------------------------------------------------------------
module ex_mem_stage
   import arm_pipe_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   ex_mem_stage_if.slave  bus
);

   logic [WIDTH-1:0] srcA;
   logic [WIDTH-1:0] fwdB;
   logic [WIDTH-1:0] srcB;
   logic [WIDTH-1:0] aluResult;
   logic [3:0]       aluFlags;
   logic [3:0]       flagReg;
   logic             condEx;
   mem_ctrl_t        ctrlNext;
   mem_ctrl_t        ctrlReg;
   logic [WIDTH-1:0] aluResultReg;
   logic [WIDTH-1:0] writeDataReg;
   logic [3:0]       wa3Reg;

   // Operand selection. Store data is the forwarded B operand taken before
   // the immediate mux, so a store of a forwarded register still works when
   // the address uses an immediate offset.
   always_comb begin
      srcA = fwdMux(bus.ForwardAE, bus.RD1E, bus.ResultW, aluResultReg);
      fwdB = fwdMux(bus.ForwardBE, bus.RD2E, bus.ResultW, aluResultReg);
      srcB = bus.CtrlE.ALUSrc ? bus.ExtImmE : fwdB;
   end

   ex_alu alu (
      .srcA   (srcA),
      .srcB   (srcB),
      .aluOp  (bus.CtrlE.ALUControl),
      .result (aluResult),
      .nzcv   (aluFlags)
   );

   // Condition is judged against the flags as they stand before this
   // instruction's own update; side effects are then gated by it.
   always_comb begin
      condEx            = condCheck(bus.CtrlE.Cond, flagReg);
      ctrlNext          = '0;
      ctrlNext.PCSrc    = bus.CtrlE.PCSrc & condEx;
      ctrlNext.RegWrite = bus.CtrlE.RegWrite & condEx;
      ctrlNext.MemtoReg = bus.CtrlE.MemtoReg;
      ctrlNext.MemWrite = bus.CtrlE.MemWrite & condEx;
   end

   // NZCV register. FlagWrite[1] covers N,Z and FlagWrite[0] covers C,V.
   // A stalled instruction must not update flags, since it will be replayed;
   // a flush of M does not cancel the instruction in EX, so it still updates.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flagReg <= 4'b0000;
      end else if (!bus.StallM && condEx) begin
         if (bus.CtrlE.FlagWrite[1]) flagReg[3:2] <= aluFlags[3:2];
         if (bus.CtrlE.FlagWrite[0]) flagReg[1:0] <= aluFlags[1:0];
      end
   end

   // EX/MEM register: reset beats flush, flush beats stall, otherwise load.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrlReg      <= '0;
         aluResultReg <= '0;
         writeDataReg <= '0;
         wa3Reg       <= 4'd0;
      end else if (bus.FlushM) begin
         ctrlReg      <= '0;
         aluResultReg <= '0;
         writeDataReg <= '0;
         wa3Reg       <= 4'd0;
      end else if (!bus.StallM) begin
         ctrlReg      <= ctrlNext;
         aluResultReg <= aluResult;
         writeDataReg <= fwdB;
         wa3Reg       <= bus.WA3E;
      end
   end

   // Branch redirect goes straight to fetch without a register.
   always_comb begin
      bus.FlagsE       = flagReg;
      bus.BranchTakenE = bus.CtrlE.Branch & condEx;
      bus.CtrlM        = ctrlReg;
      bus.ALUResultM   = aluResultReg;
      bus.WriteDataM   = writeDataReg;
      bus.WA3M         = wa3Reg;
   end

endmodule

// File: tb/tb_ex_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_stage
// Directed bench for ex_mem_stage: reset, arithmetic flags, condition gating,
// forwarding, stall/flush priority, and branch redirect.
// ---------------------------------------------------------------------------
module tb_ex_mem_stage;
   import arm_pipe_pkg::*;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   ex_mem_stage_if bus ();

   ex_mem_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // 10-unit clock period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic ex_ctrl_t mkCtrl(input logic pcSrc, input logic regWrite,
                                       input logic memToReg, input logic memWrite,
                                       input logic branch, input logic aluSrc,
                                       input alu_op_e op, input logic [1:0] flagWrite,
                                       input cond_e cond);
      ex_ctrl_t c;
      c.PCSrc      = pcSrc;
      c.RegWrite   = regWrite;
      c.MemtoReg   = memToReg;
      c.MemWrite   = memWrite;
      c.Branch     = branch;
      c.ALUSrc     = aluSrc;
      c.ALUControl = op;
      c.FlagWrite  = flagWrite;
      c.Cond       = cond;
      return c;
   endfunction

   task automatic applyStimulus(input ex_ctrl_t ctrl, input logic [31:0] rd1,
                                input logic [31:0] rd2, input logic [31:0] imm,
                                input logic [3:0] wa3, input fwd_sel_e fa,
                                input fwd_sel_e fb, input logic [31:0] resW,
                                input logic stall, input logic flush);
      bus.CtrlE     = ctrl;
      bus.RD1E      = rd1;
      bus.RD2E      = rd2;
      bus.ExtImmE   = imm;
      bus.WA3E      = wa3;
      bus.ForwardAE = fa;
      bus.ForwardBE = fb;
      bus.ResultW   = resW;
      bus.StallM    = stall;
      bus.FlushM    = flush;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      applyStimulus('0, 32'h0, 32'h0, 32'h0, 4'd0, FWD_RF, FWD_RF, 32'h0, 1'b0, 1'b0);

      // Reset state
      tick();
      checkOutput("reset_flags", {28'd0, bus.FlagsE}, 32'h0);
      checkOutput("reset_ctrlm", {28'd0, bus.CtrlM}, 32'h0);
      reset = 1'b1;

      // ADD 0x7FFFFFFF + 1 sets N and V
      applyStimulus(mkCtrl(0, 1, 0, 0, 0, 0, ALU_ADD, 2'b11, COND_AL),
                    32'h7FFF_FFFF, 32'h1, 32'h0, 4'd5, FWD_RF, FWD_RF, 32'h0, 0, 0);
      tick();
      checkOutput("add_ovf_result", bus.ALUResultM, 32'h8000_0000);
      checkOutput("add_ovf_flags", {28'd0, bus.FlagsE}, 32'h9);
      checkOutput("add_ovf_ctrlm", {28'd0, bus.CtrlM}, 32'h4);
      checkOutput("add_ovf_wa3m", {28'd0, bus.WA3M}, 32'h5);
      checkOutput("add_ovf_wdata", bus.WriteDataM, 32'h1);

      // SUB 5 - 5 sets Z and C
      applyStimulus(mkCtrl(0, 0, 0, 0, 0, 0, ALU_SUB, 2'b11, COND_AL),
                    32'h5, 32'h5, 32'h0, 4'd0, FWD_RF, FWD_RF, 32'h0, 0, 0);
      tick();
      checkOutput("sub_eq_result", bus.ALUResultM, 32'h0);
      checkOutput("sub_eq_flags", {28'd0, bus.FlagsE}, 32'h6);

      // Store under EQ executes
      applyStimulus(mkCtrl(0, 0, 0, 1, 0, 1, ALU_ADD, 2'b00, COND_EQ),
                    32'h100, 32'h55, 32'h4, 4'd0, FWD_RF, FWD_RF, 32'h0, 0, 0);
      tick();
      checkOutput("streq_ctrlm", {28'd0, bus.CtrlM}, 32'h1);
      checkOutput("streq_addr", bus.ALUResultM, 32'h104);
      checkOutput("streq_wdata", bus.WriteDataM, 32'h55);

      // Store+flag-setting SUB under NE is suppressed, flags untouched
      applyStimulus(mkCtrl(0, 1, 0, 1, 0, 0, ALU_SUB, 2'b11, COND_NE),
                    32'h1, 32'h2, 32'h0, 4'd2, FWD_RF, FWD_RF, 32'h0, 0, 0);
      tick();
      checkOutput("strne_ctrlm", {28'd0, bus.CtrlM}, 32'h0);
      checkOutput("strne_flags", {28'd0, bus.FlagsE}, 32'h6);
      checkOutput("strne_result", bus.ALUResultM, 32'hFFFF_FFFF);

      // Forward ALUResultM into A
      applyStimulus(mkCtrl(0, 1, 0, 0, 0, 0, ALU_ADD, 2'b00, COND_AL),
                    32'h10, 32'h0, 32'h0, 4'd1, FWD_RF, FWD_RF, 32'h0, 0, 0);
      tick();
      checkOutput("fwd_setup", bus.ALUResultM, 32'h10);
      applyStimulus(mkCtrl(0, 1, 0, 0, 0, 0, ALU_ADD, 2'b00, COND_AL),
                    32'hDEAD, 32'h3, 32'h0, 4'd1, FWD_MEM, FWD_RF, 32'h0, 0, 0);
      tick();
      checkOutput("fwd_mem_a", bus.ALUResultM, 32'h13);

      // Forward ResultW into store data with immediate B; A uses the 11 alias
      applyStimulus(mkCtrl(0, 1, 0, 0, 0, 1, ALU_ADD, 2'b00, COND_AL),
                    32'h1, 32'h99, 32'h20, 4'd7, FWD_RF2, FWD_WB, 32'hAB, 0, 0);
      tick();
      checkOutput("fwd_wb_wdata", bus.WriteDataM, 32'hAB);
      checkOutput("fwd_wb_result", bus.ALUResultM, 32'h21);

      // Stall holds M outputs and flags
      applyStimulus(mkCtrl(0, 0, 0, 0, 0, 0, ALU_ADD, 2'b11, COND_AL),
                    32'h8000_0000, 32'h8000_0000, 32'h0, 4'd9, FWD_RF, FWD_RF, 32'h0, 1, 0);
      tick();
      checkOutput("stall_result", bus.ALUResultM, 32'h21);
      checkOutput("stall_wdata", bus.WriteDataM, 32'hAB);
      checkOutput("stall_wa3m", {28'd0, bus.WA3M}, 32'h7);
      checkOutput("stall_ctrlm", {28'd0, bus.CtrlM}, 32'h4);
      checkOutput("stall_flags", {28'd0, bus.FlagsE}, 32'h6);

      // Stall and flush together: flush wins, flags still held
      bus.FlushM = 1'b1;
      tick();
      checkOutput("stflush_ctrlm", {28'd0, bus.CtrlM}, 32'h0);
      checkOutput("stflush_result", bus.ALUResultM, 32'h0);
      checkOutput("stflush_wdata", bus.WriteDataM, 32'h0);
      checkOutput("stflush_flags", {28'd0, bus.FlagsE}, 32'h6);

      // Flush alone still lets the EX instruction set flags
      bus.StallM = 1'b0;
      tick();
      checkOutput("flush_flags", {28'd0, bus.FlagsE}, 32'h7);
      checkOutput("flush_wa3m", {28'd0, bus.WA3M}, 32'h0);

      // Load something nonzero, then reset between edges
      applyStimulus(mkCtrl(0, 1, 0, 0, 0, 0, ALU_ORR, 2'b00, COND_AL),
                    32'h40, 32'h0, 32'h0, 4'd3, FWD_RF, FWD_RF, 32'h0, 0, 0);
      tick();
      checkOutput("prereset_result", bus.ALUResultM, 32'h40);
      reset = 1'b0;
      #2;
      checkOutput("async_reset_result", bus.ALUResultM, 32'h0);
      checkOutput("async_reset_ctrlm", {28'd0, bus.CtrlM}, 32'h0);
      checkOutput("async_reset_wa3m", {28'd0, bus.WA3M}, 32'h0);
      checkOutput("async_reset_flags", {28'd0, bus.FlagsE}, 32'h0);
      tick();

      // First edge after release loads normally: 1+1 leaves NZCV clear
      reset = 1'b1;
      applyStimulus(mkCtrl(0, 1, 0, 0, 0, 0, ALU_ADD, 2'b11, COND_AL),
                    32'h1, 32'h1, 32'h0, 4'd4, FWD_RF, FWD_RF, 32'h0, 0, 0);
      tick();
      checkOutput("release_result", bus.ALUResultM, 32'h2);
      checkOutput("release_flags", {28'd0, bus.FlagsE}, 32'h0);

      // GT with flags 0000 takes the branch in the same cycle
      applyStimulus(mkCtrl(1, 0, 0, 0, 1, 1, ALU_ADD, 2'b00, COND_GT),
                    32'h1000, 32'h0, 32'h8, 4'd15, FWD_RF, FWD_RF, 32'h0, 0, 0);
      #1;
      checkOutput("bgt_taken", {31'd0, bus.BranchTakenE}, 32'h1);
      tick();
      checkOutput("bgt_pcsrcm", {28'd0, bus.CtrlM}, 32'h8);
      checkOutput("bgt_target", bus.ALUResultM, 32'h1008);

      // Condition 1111 never executes
      applyStimulus(mkCtrl(1, 0, 0, 0, 1, 1, ALU_ADD, 2'b00, COND_NV),
                    32'h1000, 32'h0, 32'h8, 4'd15, FWD_RF, FWD_RF, 32'h0, 0, 0);
      #1;
      checkOutput("bnv_taken", {31'd0, bus.BranchTakenE}, 32'h0);
      tick();
      checkOutput("bnv_pcsrcm", {28'd0, bus.CtrlM}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
